pe_stream_scheduler: RTL and testbench

Hardware sequencer that replaces bench-driven stimulus for one PE_wrapper. On `start` it configures the PE with the layer shape and derives the word counts for ifmap, filter and ipsum. It streams those words from three local synchronous-read SRAMs into the PE input FIFOs under full-flag backpressure. It drains opsum into an output SRAM, then pulses `done`.

---
 rtl/pe_sched_pkg.sv | 24 ++
 rtl/pe_stream_loader.sv | 67 ++++++
 rtl/pe_stream_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_pe_stream_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE stream scheduler.
package pe_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_CONFIG = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Largest shape the reference network needs (AlexNet CONV1 row pass).
    localparam int W_MAX = 227;
    localparam int S_MAX = 11;
    localparam int F_MAX = 55;
    localparam int U_MAX = 4;
    localparam int N_MAX = 4;
    localparam int P_MAX = 16;
    localparam int Q_MAX = 4;

    // Filter and psum words each carry four packed values.
    localparam int WORDS_PER_PACK = 4;

endpackage

// File: rtl/pe_stream_loader.sv
// Streams `count` words from a 1-cycle-latency SRAM into a PE input FIFO,
// holding one word across FIFO backpressure.
module pe_stream_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              push,
    output logic [DATA_W-1:0] push_data,
    input  logic              full,
    output logic              finished
);

    localparam int CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // Issue a read only when the holding slot will be free when data lands.
    always_comb begin
        push       = hold_vld_q && !full;
        rd_en      = (rem_q != '0) && !inflight_q && (!hold_vld_q || push);
        rd_addr    = rd_en ? addr_q : '0;
        push_data  = hold_vld_q ? hold_q : '0;
        finished   = (rem_q == '0) && !inflight_q && !hold_vld_q;

        rem_d      = go ? count : rem_q - CNT_W'(rd_en);
        addr_d     = go ? '0 : addr_q + ADDR_W'(rd_en);
        inflight_d = rd_en;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (inflight_q) begin
            hold_vld_d = 1'b1;
            hold_d     = rd_data;
        end else if (push) begin
            hold_vld_d = 1'b0;
            hold_d     = '0;
        end
    end

    // Loader state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/pe_stream_scheduler.sv
// Sequences one PE job: check shape, configure, stream ifmap/filter/ipsum
// from local SRAMs, drain opsum to the output SRAM, pulse done.
module pe_stream_scheduler
    import pe_sched_pkg::*;
#(
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64,
    parameter int S_WIDTH           = 6,
    parameter int F_WIDTH           = 6,
    parameter int U_WIDTH           = 3,
    parameter int n_WIDTH           = 3,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int IFMAP_ADDR_WIDTH  = 12,
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PSUM_ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [S_WIDTH-1:0]           cfg_S,
    input  logic [F_WIDTH-1:0]           cfg_F,
    input  logic [U_WIDTH-1:0]           cfg_U,
    input  logic [n_WIDTH-1:0]           cfg_n,
    input  logic [p_WIDTH-1:0]           cfg_p,
    input  logic [q_WIDTH-1:0]           cfg_q,
    output logic                         busy_sched,
    output logic                         done,
    output logic                         cfg_error,
    output logic                         pe_enable,
    output logic                         pe_configure,
    output logic [S_WIDTH-1:0]           pe_S,
    output logic [F_WIDTH-1:0]           pe_F,
    output logic [U_WIDTH-1:0]           pe_U,
    output logic [n_WIDTH-1:0]           pe_n,
    output logic [p_WIDTH-1:0]           pe_p,
    output logic [q_WIDTH-1:0]           pe_q,
    output logic                         if_rd_en,
    output logic [IFMAP_ADDR_WIDTH-1:0]  if_rd_addr,
    input  logic [DATA_WIDTH_IFMAP-1:0]  if_rd_data,
    output logic                         flt_rd_en,
    output logic [FILTER_ADDR_WIDTH-1:0] flt_rd_addr,
    input  logic [DATA_WIDTH_FILTER-1:0] flt_rd_data,
    output logic                         ip_rd_en,
    output logic [PSUM_ADDR_WIDTH-1:0]   ip_rd_addr,
    input  logic [DATA_WIDTH_PSUM-1:0]   ip_rd_data,
    output logic                         push_ifmap,
    output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    input  logic                         ifmap_fifo_full,
    output logic                         push_filter,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    input  logic                         filter_fifo_full,
    output logic                         push_ipsum,
    output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    input  logic                         ipsum_fifo_full,
    output logic                         pop_opsum,
    input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
    input  logic                         opsum_fifo_empty,
    output logic                         op_wr_en,
    output logic [PSUM_ADDR_WIDTH-1:0]   op_wr_addr,
    output logic [DATA_WIDTH_PSUM-1:0]   op_wr_data
);

    localparam int IF_CAP  = 1 << IFMAP_ADDR_WIDTH;
    localparam int FLT_CAP = 1 << FILTER_ADDR_WIDTH;
    localparam int PS_CAP  = 1 << PSUM_ADDR_WIDTH;

    state_e                   state_q, state_d;
    logic [S_WIDTH-1:0]       s_q, s_d;
    logic [F_WIDTH-1:0]       f_q, f_d;
    logic [U_WIDTH-1:0]       u_q, u_d;
    logic [n_WIDTH-1:0]       n_q, n_d;
    logic [p_WIDTH-1:0]       p_q, p_d;
    logic [q_WIDTH-1:0]       q_q, q_d;
    logic                     cfg_error_q, cfg_error_d;
    logic [PSUM_ADDR_WIDTH:0] drained_q, drained_d;

    logic [9:0]  w_c;
    logic [15:0] n_if_c, n_flt_c, n_ps_c;
    logic        illegal_c, go, fin_if, fin_flt, fin_ip;

    // Word counts derived from the latched shape; stable for the whole job.
    always_comb begin
        w_c       = 10'((16'(f_q) - 16'd1) * 16'(u_q) + 16'(s_q));
        n_if_c    = 16'(16'(n_q) * 16'(w_c) * 16'(q_q));
        n_flt_c   = 16'(16'(p_q) * 16'(q_q) * 16'(s_q)) >> 2;
        n_ps_c    = 16'(16'(p_q) * 16'(n_q) * 16'(f_q)) >> 2;
        illegal_c = (s_q == '0) || (f_q == '0) || (u_q == '0) || (n_q == '0) ||
                    (p_q == '0) || (q_q == '0) || (p_q[1:0] != 2'b00) ||
                    (int'(n_if_c) > IF_CAP) || (int'(n_flt_c) > FLT_CAP) ||
                    (int'(n_ps_c) > PS_CAP);
    end

    // Static outputs decoded from the current state.
    always_comb begin
        busy_sched   = (state_q != ST_IDLE);
        pe_enable    = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        cfg_error    = cfg_error_q;
        pe_configure = (state_q == ST_CONFIG);
        go           = pe_configure;
        pe_S         = pe_configure ? s_q : '0;
        pe_F         = pe_configure ? f_q : '0;
        pe_U         = pe_configure ? u_q : '0;
        pe_n         = pe_configure ? n_q : '0;
        pe_p         = pe_configure ? p_q : '0;
        pe_q         = pe_configure ? q_q : '0;
        pop_opsum    = (state_q == ST_STREAM) && !opsum_fifo_empty &&
                       (drained_q < n_ps_c[PSUM_ADDR_WIDTH:0]);
        op_wr_en     = pop_opsum;
        op_wr_addr   = pop_opsum ? drained_q[PSUM_ADDR_WIDTH-1:0] : '0;
        op_wr_data   = pop_opsum ? opsum : '0;
    end

    // Next-state logic: shape latch, legality check, stream completion.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        f_d         = f_q;
        u_d         = u_q;
        n_d         = n_q;
        p_d         = p_q;
        q_d         = q_q;
        cfg_error_d = cfg_error_q;
        drained_d   = drained_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d     = ST_CHECK;
                s_d         = cfg_S;
                f_d         = cfg_F;
                u_d         = cfg_U;
                n_d         = cfg_n;
                p_d         = cfg_p;
                q_d         = cfg_q;
                cfg_error_d = 1'b0;
            end
            ST_CHECK: begin
                if (illegal_c) begin
                    state_d     = ST_IDLE;
                    cfg_error_d = 1'b1;
                end else begin
                    state_d = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                state_d   = ST_STREAM;
                drained_d = '0;
            end
            ST_STREAM: begin
                if (pop_opsum) drained_d = drained_q + 1'b1;
                if (fin_if && fin_flt && fin_ip &&
                    (drained_q == n_ps_c[PSUM_ADDR_WIDTH:0]))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            f_q         <= '0;
            u_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            cfg_error_q <= 1'b0;
            drained_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            f_q         <= f_d;
            u_q         <= u_d;
            n_q         <= n_d;
            p_q         <= p_d;
            q_q         <= q_d;
            cfg_error_q <= cfg_error_d;
            drained_q   <= drained_d;
        end
    end

    pe_stream_loader #(.DATA_W(DATA_WIDTH_IFMAP), .ADDR_W(IFMAP_ADDR_WIDTH)) u_ld_if (
        .clk(clk), .reset(reset), .go(go), .count(n_if_c[IFMAP_ADDR_WIDTH:0]),
        .rd_en(if_rd_en), .rd_addr(if_rd_addr), .rd_data(if_rd_data),
        .push(push_ifmap), .push_data(ifmap), .full(ifmap_fifo_full), .finished(fin_if)
    );

    pe_stream_loader #(.DATA_W(DATA_WIDTH_FILTER), .ADDR_W(FILTER_ADDR_WIDTH)) u_ld_flt (
        .clk(clk), .reset(reset), .go(go), .count(n_flt_c[FILTER_ADDR_WIDTH:0]),
        .rd_en(flt_rd_en), .rd_addr(flt_rd_addr), .rd_data(flt_rd_data),
        .push(push_filter), .push_data(filter), .full(filter_fifo_full), .finished(fin_flt)
    );

    pe_stream_loader #(.DATA_W(DATA_WIDTH_PSUM), .ADDR_W(PSUM_ADDR_WIDTH)) u_ld_ip (
        .clk(clk), .reset(reset), .go(go), .count(n_ps_c[PSUM_ADDR_WIDTH:0]),
        .rd_en(ip_rd_en), .rd_addr(ip_rd_addr), .rd_data(ip_rd_data),
        .push(push_ipsum), .push_data(ipsum), .full(ipsum_fifo_full), .finished(fin_ip)
    );

endmodule

// File: tb/tb_pe_stream_scheduler.sv
// Bench for pe_stream_scheduler: SRAM and PE FIFO models, directed job
// sequence with randomized backpressure and data.
module tb_pe_stream_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cfg_S = '0, cfg_F = '0;
    logic [2:0]  cfg_U = '0, cfg_n = '0, cfg_q = '0;
    logic [4:0]  cfg_p = '0;
    logic        busy_sched, done, cfg_error, pe_enable, pe_configure;
    logic [5:0]  pe_S, pe_F;
    logic [2:0]  pe_U, pe_n, pe_q;
    logic [4:0]  pe_p;
    logic        if_rd_en, flt_rd_en, ip_rd_en;
    logic [11:0] if_rd_addr;
    logic [7:0]  flt_rd_addr;
    logic [9:0]  ip_rd_addr;
    logic [15:0] if_rd_data = '0;
    logic [63:0] flt_rd_data = '0, ip_rd_data = '0;
    logic        push_ifmap, push_filter, push_ipsum;
    logic [15:0] ifmap;
    logic [63:0] filter, ipsum;
    logic        if_full = 1'b0, flt_full = 1'b0, ip_full = 1'b0;
    logic        pop_opsum, op_wr_en;
    logic [63:0] opsum = '0, op_wr_data;
    logic        opsum_fifo_empty = 1'b1;
    logic [9:0]  op_wr_addr;

    logic [15:0] mem_if [0:4095];
    logic [63:0] mem_flt [0:255];
    logic [63:0] mem_ip [0:1023];
    logic [63:0] golden [0:1023];

    int checks = 0;
    int errors = 0;

    pe_stream_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_U(cfg_U), .cfg_n(cfg_n), .cfg_p(cfg_p), .cfg_q(cfg_q),
        .busy_sched(busy_sched), .done(done), .cfg_error(cfg_error),
        .pe_enable(pe_enable), .pe_configure(pe_configure),
        .pe_S(pe_S), .pe_F(pe_F), .pe_U(pe_U), .pe_n(pe_n), .pe_p(pe_p), .pe_q(pe_q),
        .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr), .if_rd_data(if_rd_data),
        .flt_rd_en(flt_rd_en), .flt_rd_addr(flt_rd_addr), .flt_rd_data(flt_rd_data),
        .ip_rd_en(ip_rd_en), .ip_rd_addr(ip_rd_addr), .ip_rd_data(ip_rd_data),
        .push_ifmap(push_ifmap), .ifmap(ifmap), .ifmap_fifo_full(if_full),
        .push_filter(push_filter), .filter(filter), .filter_fifo_full(flt_full),
        .push_ipsum(push_ipsum), .ipsum(ipsum), .ipsum_fifo_full(ip_full),
        .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty),
        .op_wr_en(op_wr_en), .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAMs: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (if_rd_en)  if_rd_data  <= mem_if[if_rd_addr];
        if (flt_rd_en) flt_rd_data <= mem_flt[flt_rd_addr];
        if (ip_rd_en)  ip_rd_data  <= mem_ip[ip_rd_addr];
    end

    logic any_out;
    assign any_out = |{busy_sched, done, cfg_error, pe_enable, pe_configure,
                       pe_S, pe_F, pe_U, pe_n, pe_p, pe_q,
                       if_rd_en, if_rd_addr, flt_rd_en, flt_rd_addr, ip_rd_en, ip_rd_addr,
                       push_ifmap, ifmap, push_filter, filter, push_ipsum, ipsum,
                       pop_opsum, op_wr_en, op_wr_addr, op_wr_data};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One job from start to done (or abort); expectations come from the shape rules.
    task automatic run_job(input string nm, input int s, input int f, input int u,
                           input int nn, input int pp, input int qq,
                           input int full_pct, input int hold_lo, input int hold_hi,
                           input bit tog, input int restart_at, input int reset_at,
                           input int budget);
        int w, nif, nflt, nps;
        bit legal, aborted;
        int c_if, c_flt, c_ip, popped, produced, b_if, b_flt, b_ip, b_wr;
        int cfgs, cfg_bad, dones, rds, viol, done_k, err1, err2;
        w = (f - 1) * u + s;
        nif = nn * w * qq;
        nflt = pp * qq * s / 4;
        nps = pp * nn * f / 4;
        legal = (s != 0) && (f != 0) && (u != 0) && (nn != 0) && (pp != 0) && (qq != 0) &&
                (pp % 4 == 0) && (nif <= 4096) && (nflt <= 256) && (nps <= 1024);
        {aborted, c_if, c_flt, c_ip, popped, b_if, b_flt, b_ip, b_wr} = '0;
        {cfgs, cfg_bad, dones, rds, viol, done_k, err1, err2} = '0;
        for (int i = 0; i < 4096; i++) mem_if[i] = 16'($urandom);
        for (int i = 0; i < 256; i++)  mem_flt[i] = {$urandom, $urandom};
        for (int i = 0; i < 1024; i++) mem_ip[i] = {$urandom, $urandom};
        for (int i = 0; i < 1024; i++) golden[i] = {$urandom, $urandom};
        produced = tog ? nps : 0;

        @(negedge clk);
        cfg_S = 6'(s); cfg_F = 6'(f); cfg_U = 3'(u); cfg_n = 3'(nn); cfg_p = 5'(pp); cfg_q = 3'(qq);
        start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                chk({nm, ".reset_outputs_zero"}, 64'(any_out), 64'd0);
                aborted = 1'b1;
                break;
            end
            if_full  = (k >= hold_lo && k < hold_hi) || ($urandom_range(99) < full_pct);
            flt_full = ($urandom_range(99) < full_pct);
            ip_full  = ($urandom_range(99) < full_pct);
            if (!tog && produced < nps && $urandom_range(1) == 1) produced++;
            opsum_fifo_empty = (popped >= produced) || (tog && k % 2 == 0);
            opsum = (opsum_fifo_empty || popped >= 1024) ? 64'd0 : golden[popped];
            #1;
            if (k == 1) err1 = int'(cfg_error);
            if (k == 2) err2 = int'(cfg_error);
            if (pe_configure) begin
                cfgs++;
                if ({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q} !== {6'(s), 6'(f), 3'(u), 3'(nn), 5'(pp), 3'(qq)})
                    cfg_bad++;
            end else if ({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q} != '0) viol++;
            if (if_rd_en || flt_rd_en || ip_rd_en) rds++;
            if (push_ifmap) begin
                if (if_full) viol++;
                if (c_if >= 4096 || ifmap !== mem_if[c_if]) b_if++;
                c_if++;
            end
            if (push_filter) begin
                if (flt_full) viol++;
                if (c_flt >= 256 || filter !== mem_flt[c_flt]) b_flt++;
                c_flt++;
            end
            if (push_ipsum) begin
                if (ip_full) viol++;
                if (c_ip >= 1024 || ipsum !== mem_ip[c_ip]) b_ip++;
                c_ip++;
            end
            if (pop_opsum) begin
                if (opsum_fifo_empty) viol++;
                if (!op_wr_en || op_wr_addr !== 10'(popped) || popped >= 1024 ||
                    op_wr_data !== golden[popped]) b_wr++;
                popped++;
            end else if (op_wr_en) b_wr++;
            if (done) begin
                dones++;
                if (done_k == 0) done_k = k;
            end
            if (done_k != 0 && k >= done_k + 3) break;
        end
        start = 1'b0; if_full = 1'b0; flt_full = 1'b0; ip_full = 1'b0;
        opsum_fifo_empty = 1'b1; opsum = '0;

        if (aborted) begin
            chk({nm, ".no_done_after_abort"}, 64'(dones), 64'd0);
        end else if (legal) begin
            chk({nm, ".done_pulses"}, 64'(dones), 64'd1);
            chk({nm, ".cfg_error_cleared"}, 64'(err1), 64'd0);
            chk({nm, ".configure_cycles"}, 64'(cfgs), 64'd1);
            chk({nm, ".configure_shape_bad"}, 64'(cfg_bad), 64'd0);
            chk({nm, ".ifmap_pushes"}, 64'(c_if), 64'(nif));
            chk({nm, ".filter_pushes"}, 64'(c_flt), 64'(nflt));
            chk({nm, ".ipsum_pushes"}, 64'(c_ip), 64'(nps));
            chk({nm, ".opsum_writes"}, 64'(popped), 64'(nps));
            chk({nm, ".ifmap_order_bad"}, 64'(b_if), 64'd0);
            chk({nm, ".filter_order_bad"}, 64'(b_flt), 64'd0);
            chk({nm, ".ipsum_order_bad"}, 64'(b_ip), 64'd0);
            chk({nm, ".opsum_write_bad"}, 64'(b_wr), 64'd0);
            chk({nm, ".protocol_violations"}, 64'(viol), 64'd0);
            chk({nm, ".idle_after_done"}, 64'(busy_sched), 64'd0);
        end else begin
            chk({nm, ".cfg_error_at_2"}, 64'(err2), 64'd1);
            chk({nm, ".cfg_error_sticky"}, 64'(cfg_error), 64'd1);
            chk({nm, ".no_configure"}, 64'(cfgs), 64'd0);
            chk({nm, ".no_sram_reads"}, 64'(rds), 64'd0);
            chk({nm, ".no_done"}, 64'(dones), 64'd0);
            chk({nm, ".idle_after_error"}, 64'(busy_sched), 64'd0);
        end
    endtask

    initial begin
        int rs, rf, ru, rn, rp, rq;
        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        chk("por.outputs_zero", 64'(any_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("por.idle_after_release", 64'(any_out), 64'd0);

        run_job("small",      3, 4, 1, 1, 4, 1,   0,   0,   0, 1'b0,  0,  0, 400);
        run_job("p6_error",   3, 4, 1, 1, 6, 1,   0,   0,   0, 1'b0,  0,  0, 8);
        run_job("small2",     3, 4, 1, 1, 4, 1,   0,   0,   0, 1'b0,  0,  0, 400);
        run_job("oversize",  63,63, 7, 7,28, 7,   0,   0,   0, 1'b0,  0,  0, 8);
        run_job("alexnet",   11,55, 4, 1,16, 1,   0,   0,   0, 1'b0,  0,  0, 4000);
        run_job("if_hold",   11,55, 4, 1,16, 1,  20, 100, 120, 1'b0,  0,  0, 6000);
        run_job("restart",    5, 8, 2, 2, 8, 2,  10,   0,   0, 1'b1, 20,  0, 4000);
        run_job("rst_mid",   11,55, 4, 1,16, 1,   0,   0,   0, 1'b0,  0, 50, 4000);
        @(negedge clk);
        reset = 1'b1;
        run_job("post_rst",   3, 4, 1, 1, 4, 1,   0,   0,   0, 1'b0,  0,  0, 400);

        for (int j = 0; j < 3; j++) begin
            rs = int'($urandom_range(11, 1));
            rf = int'($urandom_range(20, 1));
            ru = int'($urandom_range(4, 1));
            rn = int'($urandom_range(4, 1));
            rp = 4 * int'($urandom_range(4, 1));
            rq = int'($urandom_range(4, 1));
            run_job($sformatf("rand%0d", j), rs, rf, ru, rn, rp, rq,
                    30, 0, 0, 1'b0, 0, 0, 9000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
